// File: rtl/lfsr_pkg.sv
// Shared types and defaults for the programmable LFSR generator.
package lfsr_pkg;

    // Feedback structure selected at load time
    typedef enum logic {
        LFSR_GALOIS    = 1'b0,
        LFSR_FIBONACCI = 1'b1
    } lfsr_mode_e;

    localparam int unsigned LFSR_DEFAULT_WIDTH = 6;

    // Default tap mask (x^6 + x^4 + x + 1 style taps); zero-extended for wider registers
    localparam logic [5:0] LFSR_DEFAULT_POLY = 6'b010011;

endpackage : lfsr_pkg

// File: rtl/lfsr_if.sv
// Control/data bundle between an LFSR client (master) and the generator (slave).
interface lfsr_if #(
    parameter int unsigned WIDTH = 6
);

    logic             en;
    logic             ld;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] poly;
    logic             mode;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             wrap;
    logic             lockup;
    logic [WIDTH-1:0] period;

    modport master (
        output en, ld, seed, poly, mode,
        input  q, sout, wrap, lockup, period
    );

    modport slave (
        input  en, ld, seed, poly, mode,
        output q, sout, wrap, lockup, period
    );

endinterface : lfsr_if

// File: rtl/lfsr_next.sv
// Combinational next-state function for Galois or Fibonacci LFSR.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH = LFSR_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_poly,
    input  lfsr_mode_e       i_mode,
    output logic [WIDTH-1:0] o_next
);

    logic [WIDTH-1:0] w_shift;
    logic             w_fb;

    // Galois: shifted-out MSB folds the tap mask back in; Fibonacci: parity of tapped bits shifts in
    always_comb begin
        w_shift = {i_q[WIDTH-2:0], 1'b0};
        w_fb    = ^(i_q & i_poly);
        o_next  = w_shift;
        if (i_mode == LFSR_FIBONACCI) begin
            o_next = {i_q[WIDTH-2:0], w_fb};
        end else if (i_q[WIDTH-1]) begin
            o_next = w_shift ^ i_poly;
        end
    end

endmodule : lfsr_next

// File: rtl/lfsr_gen.sv
// Runtime-programmable LFSR with lock-up recovery and on-line period measurement.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH      = LFSR_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_SEED = '1,
    parameter logic [WIDTH-1:0] RESET_POLY = WIDTH'(LFSR_DEFAULT_POLY)
) (
    input  logic  clk,
    input  logic  rst_b,
    lfsr_if.slave bus
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_start;
    logic [WIDTH-1:0] r_poly;
    lfsr_mode_e       r_mode;
    logic [WIDTH-1:0] r_step_cnt;
    logic [WIDTH-1:0] r_period;
    logic             r_wrap;
    logic             r_lockup;

    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_cnt_inc;

    lfsr_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .i_q    (r_q),
        .i_poly (r_poly),
        .i_mode (r_mode),
        .o_next (w_next)
    );

    // Saturating step count; also used as the period value on wrap
    always_comb begin
        w_cnt_inc = r_step_cnt;
        if (r_step_cnt != '1) begin
            w_cnt_inc = r_step_cnt + WIDTH'(1);
        end
    end

    // State, start marker, configuration, counters and event pulses
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_q        <= RESET_SEED;
            r_start    <= RESET_SEED;
            r_poly     <= RESET_POLY;
            r_mode     <= LFSR_GALOIS;
            r_step_cnt <= '0;
            r_period   <= '0;
            r_wrap     <= 1'b0;
            r_lockup   <= 1'b0;
        end else begin
            r_wrap   <= 1'b0;
            r_lockup <= 1'b0;
            if (bus.ld) begin
                r_poly     <= bus.poly;
                r_mode     <= lfsr_mode_e'(bus.mode);
                r_step_cnt <= '0;
                if (bus.seed == '0) begin
                    r_q      <= RESET_SEED;
                    r_start  <= RESET_SEED;
                    r_lockup <= 1'b1;
                end else begin
                    r_q     <= bus.seed;
                    r_start <= bus.seed;
                end
            end else if (bus.en) begin
                if (w_next == '0) begin
                    r_q        <= RESET_SEED;
                    r_start    <= RESET_SEED;
                    r_step_cnt <= '0;
                    r_lockup   <= 1'b1;
                end else if (w_next == r_start) begin
                    r_q        <= w_next;
                    r_wrap     <= 1'b1;
                    r_period   <= w_cnt_inc;
                    r_step_cnt <= '0;
                end else begin
                    r_q        <= w_next;
                    r_step_cnt <= w_cnt_inc;
                end
            end
        end
    end

    assign bus.q      = r_q;
    assign bus.sout   = r_q[WIDTH-1];
    assign bus.wrap   = r_wrap;
    assign bus.lockup = r_lockup;
    assign bus.period = r_period;

endmodule : lfsr_gen
